// File: rtl/alu_cmd_engine.sv
// Command sequencer owning an 8-entry register file and driving the shared ALU.
// Define ALU_CMD_STATUS_NV_EN to track N and V in status; otherwise only Z.
module alu_cmd_engine #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_kind,
  input  logic [1:0]   cmd_op,
  input  logic [2:0]   cmd_rd,
  input  logic [2:0]   cmd_rn,
  input  logic [2:0]   cmd_rm,
  input  logic [W-1:0] cmd_imm,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [1:0]   alu_op,
  input  logic [W-1:0] alu_out,
  input  logic         alu_z,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_data,
  output logic [2:0]   status,
  input  logic [2:0]   dbg_sel,
  output logic [W-1:0] dbg_data
);

  typedef enum logic [2:0] {
    IDLE, LOAD_A, LOAD_B, EXEC, RESP
  } state_t;

  state_t state, state_nx;

  logic [W-1:0] rf [0:7];
  logic [W-1:0] a_reg, b_reg;
  logic [1:0]   op_reg;
  logic [2:0]   rd_reg, rn_reg, rm_reg;
  logic         accept;
  logic         n_nx, v_nx;

  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign alu_a     = a_reg;
  assign alu_b     = b_reg;
  assign alu_op    = op_reg;
  assign dbg_data  = rf[dbg_sel];

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = cmd_kind ? RESP : LOAD_A;
      LOAD_A:  state_nx = LOAD_B;
      LOAD_B:  state_nx = EXEC;
      EXEC:    state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    n_nx = 1'b0;
    v_nx = 1'b0;
`ifdef ALU_CMD_STATUS_NV_EN
    n_nx = alu_out[W-1];
    unique case (op_reg)
      2'b00:   v_nx = (a_reg[W-1] == b_reg[W-1]) &&
                      (alu_out[W-1] != a_reg[W-1]);
      2'b01:   v_nx = (a_reg[W-1] != b_reg[W-1]) &&
                      (alu_out[W-1] != a_reg[W-1]);
      default: v_nx = 1'b0;
    endcase
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) rf[i] <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      op_reg    <= '0;
      rd_reg    <= '0;
      rn_reg    <= '0;
      rm_reg    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      status    <= '0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          op_reg <= cmd_op;
          rd_reg <= cmd_rd;
          rn_reg <= cmd_rn;
          rm_reg <= cmd_rm;
          if (cmd_kind) begin
            rf[cmd_rd] <= cmd_imm;
            rsp_data   <= cmd_imm;
            rsp_valid  <= 1'b1;
          end
        end
        LOAD_A: a_reg <= rf[rn_reg];
        LOAD_B: b_reg <= rf[rm_reg];
        EXEC: begin
          rf[rd_reg] <= alu_out;
          rsp_data   <= alu_out;
          status     <= {v_nx, n_nx, alu_z};
          rsp_valid  <= 1'b1;
        end
        RESP: if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_engine.sv
// Directed bench for alu_cmd_engine with a behavioural ALU.
// Status expectations follow ALU_CMD_STATUS_NV_EN when defined.
module tb_alu_cmd_engine;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic         cmd_kind = 1'b0;
  logic [1:0]   cmd_op = '0;
  logic [2:0]   cmd_rd = '0;
  logic [2:0]   cmd_rn = '0;
  logic [2:0]   cmd_rm = '0;
  logic [W-1:0] cmd_imm = '0;
  logic [W-1:0] alu_a, alu_b;
  logic [1:0]   alu_op;
  logic [W-1:0] alu_out;
  logic         alu_z;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_data;
  logic [2:0]   status;
  logic [2:0]   dbg_sel = '0;
  logic [W-1:0] dbg_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    alu_out = '0;
    case (alu_op)
      2'b00: alu_out = alu_a + alu_b;
      2'b01: alu_out = alu_a - alu_b;
      2'b10: alu_out = alu_a & alu_b;
      2'b11: alu_out = ~alu_b;
      default: alu_out = '0;
    endcase
  end
  assign alu_z = (alu_out == '0);

  alu_cmd_engine #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_kind(cmd_kind), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_rn(cmd_rn), .cmd_rm(cmd_rm),
    .cmd_imm(cmd_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_z(alu_z),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .status(status),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reg(input logic [2:0] idx,
                           input logic [W-1:0] exp);
    dbg_sel = idx;
    #1;
    check($sformatf("dbg R%0d", idx), 32'(dbg_data), 32'(exp));
  endtask

  task automatic accept_cmd(input logic kind, input logic [1:0] op,
                            input logic [2:0] rd, input logic [2:0] rn,
                            input logic [2:0] rm, input logic [W-1:0] imm);
    check("cmd_ready before accept", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_kind  = kind;
    cmd_op    = op;
    cmd_rd    = rd;
    cmd_rn    = rn;
    cmd_rm    = rm;
    cmd_imm   = imm;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Full command: accept, measure latency, check result, take response.
  task automatic do_cmd(input string tag, input logic kind,
                        input logic [1:0] op, input logic [2:0] rd,
                        input logic [2:0] rn, input logic [2:0] rm,
                        input logic [W-1:0] imm, input logic [W-1:0] exp_d,
                        input logic [2:0] exp_st);
    int lat;
    accept_cmd(kind, op, rd, rn, rm, imm);
    lat = 0;
    while (!rsp_valid && lat < 10) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, 32'(lat), kind ? 32'd0 : 32'd3);
    check({tag, " rsp_data"}, 32'(rsp_data), 32'(exp_d));
    check({tag, " status"}, 32'(status), 32'(exp_st));
    check_reg(rd, exp_d);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({tag, " rsp_valid drop"}, 32'(rsp_valid), 32'd0);
    check({tag, " cmd_ready back"}, 32'(cmd_ready), 32'd1);
  endtask

  logic [2:0] st_not, st_ovf_add, st_ovf_sub, st_bp;

  initial begin
`ifdef ALU_CMD_STATUS_NV_EN
    st_not     = 3'b010;
    st_ovf_add = 3'b110;
    st_ovf_sub = 3'b100;
    st_bp      = 3'b010;
`else
    st_not     = 3'b000;
    st_ovf_add = 3'b000;
    st_ovf_sub = 3'b000;
    st_bp      = 3'b000;
`endif
    #12;
    check("reset cmd_ready", 32'(cmd_ready), 32'd1);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;
    tick();

    // Abort mid-EXEC: destination must stay unwritten.
    do_cmd("pre ld0", 1'b1, 2'b00, 3'd0, 3'd0, 3'd0, 16'd5, 16'd5, 3'b000);
    do_cmd("pre ld1", 1'b1, 2'b00, 3'd1, 3'd0, 3'd0, 16'd6, 16'd6, 3'b000);
    accept_cmd(1'b0, 2'b01, 3'd7, 3'd0, 3'd1, '0);
    tick();
    tick();
    check("exec alu_a", 32'(alu_a), 32'd5);
    check("exec alu_b", 32'(alu_b), 32'd6);
    check("exec alu_op", 32'(alu_op), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst rsp_data", 32'(rsp_data), 32'd0);
    check("rst status", 32'(status), 32'd0);
    check("rst alu_a", 32'(alu_a), 32'd0);
    check("rst alu_b", 32'(alu_b), 32'd0);
    check("rst alu_op", 32'(alu_op), 32'd0);
    for (int i = 0; i < 8; i++) check_reg(3'(i), '0);
    rst_n = 1'b1;
    tick();
    tick();
    check_reg(3'd7, '0);
    check("post-rst rsp_valid", 32'(rsp_valid), 32'd0);

    do_cmd("ld R0", 1'b1, 2'b00, 3'd0, 3'd0, 3'd0, 16'd17, 16'd17, 3'b000);
    do_cmd("ld R1", 1'b1, 2'b00, 3'd1, 3'd0, 3'd0, 16'd29, 16'd29, 3'b000);
    do_cmd("add", 1'b0, 2'b00, 3'd2, 3'd0, 3'd1, '0, 16'd46, 3'b000);
    do_cmd("sub", 1'b0, 2'b01, 3'd3, 3'd1, 3'd1, '0, 16'd0, 3'b001);
    do_cmd("and", 1'b0, 2'b10, 3'd6, 3'd0, 3'd1, '0, 16'd17, 3'b000);
    do_cmd("not", 1'b0, 2'b11, 3'd4, 3'd0, 3'd5, '0, 16'hFFFF, st_not);
    do_cmd("ld keeps st", 1'b1, 2'b00, 3'd5, 3'd0, 3'd0,
           16'h1234, 16'h1234, st_not);
    do_cmd("ld 7fff", 1'b1, 2'b00, 3'd0, 3'd0, 3'd0,
           16'h7FFF, 16'h7FFF, st_not);
    do_cmd("ld 1", 1'b1, 2'b00, 3'd1, 3'd0, 3'd0, 16'd1, 16'd1, st_not);
    do_cmd("ovf add", 1'b0, 2'b00, 3'd2, 3'd0, 3'd1, '0, 16'h8000,
           st_ovf_add);
    do_cmd("ovf sub", 1'b0, 2'b01, 3'd3, 3'd2, 3'd1, '0, 16'h7FFF,
           st_ovf_sub);
    do_cmd("alias", 1'b0, 2'b00, 3'd1, 3'd1, 3'd1, '0, 16'd2, 3'b000);

    // Idle rsp_ready has no effect.
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("idle rsp_ready valid", 32'(rsp_valid), 32'd0);
    check("idle rsp_ready ready", 32'(cmd_ready), 32'd1);

    // Backpressure: R2=0x8000 + R3=0x7FFF = 0xFFFF.
    accept_cmd(1'b0, 2'b00, 3'd0, 3'd2, 3'd3, '0);
    tick();
    tick();
    tick();
    check("bp rsp_valid", 32'(rsp_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      cmd_valid = i[0];
      cmd_kind  = 1'b1;
      cmd_rd    = 3'd6;
      cmd_imm   = 16'hBEEF;
      tick();
      check("bp hold valid", 32'(rsp_valid), 32'd1);
      check("bp hold data", 32'(rsp_data), 32'hFFFF);
      check("bp hold status", 32'(status), 32'(st_bp));
      check("bp cmd_ready", 32'(cmd_ready), 32'd0);
    end
    cmd_valid = 1'b0;
    check_reg(3'd6, 16'd17);
    check_reg(3'd0, 16'hFFFF);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp release ready", 32'(cmd_ready), 32'd1);
    check("bp release valid", 32'(rsp_valid), 32'd0);
    tick();
    check_reg(3'd6, 16'd17);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
